// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: EX and LD requesters, each with a one-entry buffer,
// sharing a single byte-enabled gprc write port through a registered issue stage.
module wb_arbiter #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int AW      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [AW-1:0]     ex_dst,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [1:0]        ex_be,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_dst,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [1:0]        ld_be,
  output logic              rf_we,
  output logic [AW-1:0]     rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [1:0]        rf_be,
  output logic [REG_CNT-1:0] busy_mask
);

  typedef struct packed {
    logic              v;
    logic [AW-1:0]     dst;
    logic [DATA_W-1:0] data;
    logic [1:0]        be;
    logic              age;
  } buf_t;

  buf_t ex_b, ld_b;
  logic rr;  // 0: EX wins the next same-age contest, 1: LD
  logic ex_grant, ld_grant, ex_load, ld_load;

  always_comb begin
    ex_grant = 1'b0;
    ld_grant = 1'b0;
    if (ex_b.v && ld_b.v) begin
      if (ex_b.age != ld_b.age)       ld_grant = ex_b.age;
      else if (ex_b.dst == ld_b.dst)  ld_grant = 1'b1;  // EX is the younger instruction
      else                            ld_grant = rr;
      ex_grant = !ld_grant;
    end else begin
      ex_grant = ex_b.v;
      ld_grant = ld_b.v;
    end
  end

  assign ex_ready = !rst && (!ex_b.v || ex_grant);
  assign ld_ready = !rst && (!ld_b.v || ld_grant);
  assign ex_load  = ex_valid && ex_ready && (ex_be != 2'b00);
  assign ld_load  = ld_valid && ld_ready && (ld_be != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_b    <= '0;
      ld_b    <= '0;
      rr      <= 1'b0;
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      rf_be   <= '0;
    end else begin
      rf_we <= ex_grant || ld_grant;
      if (ex_grant) begin
        rf_addr <= ex_b.dst;
        rf_data <= ex_b.data;
        rf_be   <= ex_b.be;
      end else if (ld_grant) begin
        rf_addr <= ld_b.dst;
        rf_data <= ld_b.data;
        rf_be   <= ld_b.be;
      end
      if (ex_b.v && ld_b.v) rr <= ex_grant;

      // A new entry is younger only if the other buffer keeps its entry past this edge.
      if (ex_load) begin
        ex_b <= '{v: 1'b1, dst: ex_dst, data: ex_data, be: ex_be,
                  age: ld_b.v && !ld_grant};
      end else begin
        if (ex_grant) ex_b.v   <= 1'b0;
        if (ld_load)  ex_b.age <= 1'b0;
      end
      if (ld_load) begin
        ld_b <= '{v: 1'b1, dst: ld_dst, data: ld_data, be: ld_be,
                  age: ex_b.v && !ex_grant};
      end else begin
        if (ld_grant) ld_b.v   <= 1'b0;
        if (ex_load)  ld_b.age <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < REG_CNT; r++) begin
      busy_mask[r] = (ex_b.v && ex_b.dst == AW'(r)) || (ld_b.v && ld_b.dst == AW'(r)) ||
                     (rf_we && rf_addr == AW'(r));
    end
  end

endmodule
